time_keeper_bcd: RTL and testbench

- Parametrised successor to the single-rate hour/minute counter.
- Keeps BCD time of day HH:MM:SS from the system clock. Adds a configurable prescaler, a seconds field, 12/24-hour display mode, pause, validated time-set load, and a minute-resolution alarm.
- Sits between the system clock domain and the display/alarm logic, and supplies the slow strobe clock and per-unit enable pulses to downstream blocks.

---
 rtl/time_keeper_bcd.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_time_keeper_bcd.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_keeper_bcd.sv
// time_keeper_bcd
// BCD time-of-day keeper (HH:MM:SS, held internally in 24 h form) driven from
// the system clock through a prescaler. It also produces a free-running slow
// strobe clock, per-unit enable pulses, a 12/24 h display mapping, a validated
// time-set load and a minute-resolution alarm.
module time_keeper_bcd #(
    parameter int TICKS_PER_SEC = 1000000,  // clk cycles per second, >= 2
    parameter int SLOW_HALF     = 1000,     // clk cycles per clk_slow half-period, >= 1
    parameter bit ALARM_EN      = 1'b1      // 0 removes the alarm compare
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run_en,
    input  logic       mode_12h,
    input  logic       set_valid,
    input  logic [7:0] set_hh,
    input  logic [7:0] set_mm,
    input  logic [7:0] set_ss,
    input  logic       alarm_en,
    input  logic [7:0] alarm_hh,
    input  logic [7:0] alarm_mm,
    output logic       clk_slow,
    output logic       sec_en,
    output logic       min_en,
    output logic       day_en,
    output logic [1:0] hour_tens,
    output logic [3:0] hour_units,
    output logic [2:0] min_tens,
    output logic [3:0] min_units,
    output logic [2:0] sec_tens,
    output logic [3:0] sec_units,
    output logic       pm,
    output logic       set_err,
    output logic       alarm_hit
);

    // Counter widths; the slow counter keeps one bit even when SLOW_HALF is 1.
    localparam int PRE_W  = $clog2(TICKS_PER_SEC);
    localparam int SLOW_W = (SLOW_HALF > 1) ? $clog2(SLOW_HALF) : 1;

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICKS_PER_SEC - 1);
    localparam logic [SLOW_W-1:0] SLOW_LAST = SLOW_W'(SLOW_HALF - 1);

    // Slow strobe divider
    logic [SLOW_W-1:0] r_slow_cnt;
    logic              r_clk_slow;

    // Prescaler
    logic [PRE_W-1:0]  r_pre;

    // Time of day, 24 h BCD digits
    logic [1:0] r_hr_t;
    logic [3:0] r_hr_u;
    logic [2:0] r_min_t;
    logic [3:0] r_min_u;
    logic [2:0] r_sec_t;
    logic [3:0] r_sec_u;

    // Registered event pulses
    logic r_sec_en;
    logic r_min_en;
    logic r_day_en;
    logic r_set_err;

    // Time after one more second, plus the carries that produce it
    logic [1:0] w_nxt_hr_t;
    logic [3:0] w_nxt_hr_u;
    logic [2:0] w_nxt_min_t;
    logic [3:0] w_nxt_min_u;
    logic [2:0] w_nxt_sec_t;
    logic [3:0] w_nxt_sec_u;
    logic       w_sec_wrap;
    logic       w_min_wrap;
    logic       w_day_wrap;

    logic       w_tick;
    logic       w_set_fields_ok;
    logic       w_set_load;
    logic       w_set_bad;

    logic [4:0] w_hour_bin;
    logic [4:0] w_disp_bin;

    // ------------------------------------------------------------------
    // Slow strobe: free-running, ignores run_en and set requests.
    // ------------------------------------------------------------------
    // Divide clk down to a square wave with a half-period of SLOW_HALF cycles.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop in the
        // block samples pre-edge values regardless of statement order.
        if (rst) begin
            r_slow_cnt <= '0;
            r_clk_slow <= 1'b0;
        end else if (r_slow_cnt == SLOW_LAST) begin
            r_slow_cnt <= '0;
            r_clk_slow <= ~r_clk_slow;
        end else begin
            r_slow_cnt <= r_slow_cnt + 1'b1;
        end
    end

    assign clk_slow = r_clk_slow;

    // ------------------------------------------------------------------
    // Set request validation: all nibbles decimal, hh <= 23, tens <= 5.
    // ------------------------------------------------------------------
    assign w_set_fields_ok = (set_hh[3:0] <= 4'd9) &&
                             (set_mm[3:0] <= 4'd9) &&
                             (set_ss[3:0] <= 4'd9) &&
                             ((set_hh[7:4] <= 4'd1) ||
                              ((set_hh[7:4] == 4'd2) && (set_hh[3:0] <= 4'd3))) &&
                             (set_mm[7:4] <= 4'd5) &&
                             (set_ss[7:4] <= 4'd5);

    assign w_set_load = set_valid && w_set_fields_ok;
    assign w_set_bad  = set_valid && !w_set_fields_ok;

    // A tick is the prescaler's terminal count while running.
    assign w_tick = run_en && (r_pre == PRE_LAST);

    // Prescaler: counts only while running, restarts on an accepted set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre <= '0;
        end else if (w_set_load) begin
            r_pre <= '0;
        end else if (run_en) begin
            if (r_pre == PRE_LAST) begin
                r_pre <= '0;
            end else begin
                r_pre <= r_pre + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // One-second advance: each digit moves only when the one below wraps.
    // ------------------------------------------------------------------
    // Compute the time one second ahead of the current state.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        w_nxt_hr_t  = r_hr_t;
        w_nxt_hr_u  = r_hr_u;
        w_nxt_min_t = r_min_t;
        w_nxt_min_u = r_min_u;
        w_nxt_sec_t = r_sec_t;
        w_nxt_sec_u = r_sec_u;

        w_sec_wrap = (r_sec_t == 3'd5) && (r_sec_u == 4'd9);
        w_min_wrap = w_sec_wrap && (r_min_t == 3'd5) && (r_min_u == 4'd9);
        w_day_wrap = w_min_wrap && (r_hr_t == 2'd2) && (r_hr_u == 4'd3);

        if (r_sec_u == 4'd9) begin
            w_nxt_sec_u = 4'd0;
            w_nxt_sec_t = (r_sec_t == 3'd5) ? 3'd0 : r_sec_t + 3'd1;
        end else begin
            w_nxt_sec_u = r_sec_u + 4'd1;
        end

        if (w_sec_wrap) begin
            if (r_min_u == 4'd9) begin
                w_nxt_min_u = 4'd0;
                w_nxt_min_t = (r_min_t == 3'd5) ? 3'd0 : r_min_t + 3'd1;
            end else begin
                w_nxt_min_u = r_min_u + 4'd1;
            end
        end

        if (w_min_wrap) begin
            if (w_day_wrap) begin
                w_nxt_hr_t = 2'd0;
                w_nxt_hr_u = 4'd0;
            end else if (r_hr_u == 4'd9) begin
                w_nxt_hr_u = 4'd0;
                w_nxt_hr_t = r_hr_t + 2'd1;
            end else begin
                w_nxt_hr_u = r_hr_u + 4'd1;
            end
        end
    end

    // Time register: an accepted set wins over a coinciding tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hr_t  <= 2'd0;
            r_hr_u  <= 4'd0;
            r_min_t <= 3'd0;
            r_min_u <= 4'd0;
            r_sec_t <= 3'd0;
            r_sec_u <= 4'd0;
        end else if (w_set_load) begin
            r_hr_t  <= set_hh[5:4];
            r_hr_u  <= set_hh[3:0];
            r_min_t <= set_mm[6:4];
            r_min_u <= set_mm[3:0];
            r_sec_t <= set_ss[6:4];
            r_sec_u <= set_ss[3:0];
        end else if (w_tick) begin
            r_hr_t  <= w_nxt_hr_t;
            r_hr_u  <= w_nxt_hr_u;
            r_min_t <= w_nxt_min_t;
            r_min_u <= w_nxt_min_u;
            r_sec_t <= w_nxt_sec_t;
            r_sec_u <= w_nxt_sec_u;
        end
    end

    // Event pulses, aligned with the digits they describe; a load drops the tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sec_en  <= 1'b0;
            r_min_en  <= 1'b0;
            r_day_en  <= 1'b0;
            r_set_err <= 1'b0;
        end else begin
            r_sec_en  <= w_tick && !w_set_load;
            r_min_en  <= w_tick && !w_set_load && w_sec_wrap;
            r_day_en  <= w_tick && !w_set_load && w_day_wrap;
            r_set_err <= w_set_bad;
        end
    end

    assign sec_en  = r_sec_en;
    assign min_en  = r_min_en;
    assign day_en  = r_day_en;
    assign set_err = r_set_err;

    // ------------------------------------------------------------------
    // Display mapping, combinational from state.
    // ------------------------------------------------------------------
    assign w_hour_bin = 5'(r_hr_t) * 5'd10 + 5'(r_hr_u);
    assign pm         = (w_hour_bin >= 5'd12);

    // Map the internal hour to 24 h or 12 h display digits.
    always_comb begin
        w_disp_bin = w_hour_bin;
        hour_tens  = r_hr_t;
        hour_units = r_hr_u;
        if (mode_12h) begin
            if (w_hour_bin == 5'd0) begin
                w_disp_bin = 5'd12;
            end else if (w_hour_bin > 5'd12) begin
                w_disp_bin = w_hour_bin - 5'd12;
            end
            if (w_disp_bin >= 5'd10) begin
                hour_tens  = 2'd1;
                hour_units = 4'(w_disp_bin - 5'd10);
            end else begin
                hour_tens  = 2'd0;
                hour_units = 4'(w_disp_bin);
            end
        end
    end

    assign min_tens  = r_min_t;
    assign min_units = r_min_u;
    assign sec_tens  = r_sec_t;
    assign sec_units = r_sec_u;

    // ------------------------------------------------------------------
    // Alarm: fires when a tick lands on alarm_hh:alarm_mm:00. The compare is
    // against a legal time, so out-of-range alarm settings simply never match.
    // ------------------------------------------------------------------
    if (ALARM_EN) begin : g_alarm
        logic w_alarm_match;
        logic r_alarm_hit;

        assign w_alarm_match = alarm_en && w_sec_wrap &&
                               ({2'b00, w_nxt_hr_t, w_nxt_hr_u} == alarm_hh) &&
                               ({1'b0, w_nxt_min_t, w_nxt_min_u} == alarm_mm);

        // Register the alarm pulse; loads never fire it.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_alarm_hit <= 1'b0;
            end else begin
                r_alarm_hit <= w_tick && !w_set_load && w_alarm_match;
            end
        end

        assign alarm_hit = r_alarm_hit;
    end else begin : g_no_alarm
        assign alarm_hit = 1'b0;
    end

endmodule

// File: tb/tb_time_keeper_bcd.sv
// Testbench for time_keeper_bcd: directed scenarios plus randomized stimulus,
// all compared against a seconds-of-day reference model.
module tb_time_keeper_bcd;

    localparam int T  = 4;  // TICKS_PER_SEC
    localparam int SH = 3;  // SLOW_HALF

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run_en = 1'b0;
    logic       mode_12h = 1'b0;
    logic       set_valid = 1'b0;
    logic [7:0] set_hh = 8'h00;
    logic [7:0] set_mm = 8'h00;
    logic [7:0] set_ss = 8'h00;
    logic       alarm_en = 1'b0;
    logic [7:0] alarm_hh = 8'h00;
    logic [7:0] alarm_mm = 8'h00;
    logic       clk_slow, sec_en, min_en, day_en, pm, set_err, alarm_hit;
    logic [1:0] hour_tens;
    logic [3:0] hour_units;
    logic [2:0] min_tens;
    logic [3:0] min_units;
    logic [2:0] sec_tens;
    logic [3:0] sec_units;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_secs, m_pre, m_slow_cnt;
    bit m_slow, m_sec_en, m_min_en, m_day_en, m_set_err, m_alarm;

    always #5 clk = ~clk;

    time_keeper_bcd #(.TICKS_PER_SEC(T), .SLOW_HALF(SH), .ALARM_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .run_en(run_en), .mode_12h(mode_12h),
        .set_valid(set_valid), .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
        .alarm_en(alarm_en), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm),
        .clk_slow(clk_slow), .sec_en(sec_en), .min_en(min_en), .day_en(day_en),
        .hour_tens(hour_tens), .hour_units(hour_units), .min_tens(min_tens),
        .min_units(min_units), .sec_tens(sec_tens), .sec_units(sec_units),
        .pm(pm), .set_err(set_err), .alarm_hit(alarm_hit)
    );

    // Decimal value of a BCD byte, or -1 if a nibble is not a decimal digit.
    function automatic int bcd_val(input logic [7:0] b);
        if (b[7:4] > 4'd9 || b[3:0] > 4'd9) return -1;
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Expected display digits for decimal hour/minute/second.
    function automatic logic [19:0] hms(input int h, input int mi, input int s);
        return {2'(h / 10), 4'(h % 10), 3'(mi / 10), 4'(mi % 10), 3'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [19:0] dut_time();
        return {hour_tens, hour_units, min_tens, min_units, sec_tens, sec_units};
    endfunction

    function automatic logic [26:0] dut_vec();
        return {clk_slow, sec_en, min_en, day_en, dut_time(), pm, set_err, alarm_hit};
    endfunction

    // Expected outputs from the model's seconds-of-day and the current mode.
    function automatic logic [26:0] model_vec();
        int h, mi, s, dh;
        h  = m_secs / 3600;
        mi = (m_secs / 60) % 60;
        s  = m_secs % 60;
        dh = mode_12h ? ((h % 12 == 0) ? 12 : h % 12) : h;
        return {m_slow, m_sec_en, m_min_en, m_day_en, hms(dh, mi, s),
                (h >= 12), m_set_err, m_alarm};
    endfunction

    // Advance the model by one clk edge using the inputs present at that edge.
    task automatic model_step();
        int h, mi, s, ah, am;
        bit tick, ok;
        if (rst) begin
            m_secs = 0; m_pre = 0; m_slow_cnt = 0; m_slow = 0;
            m_sec_en = 0; m_min_en = 0; m_day_en = 0; m_set_err = 0; m_alarm = 0;
        end else begin
            if (m_slow_cnt == SH - 1) begin
                m_slow_cnt = 0;
                m_slow = ~m_slow;
            end else begin
                m_slow_cnt++;
            end
            tick = run_en && (m_pre == T - 1);
            h  = bcd_val(set_hh);
            mi = bcd_val(set_mm);
            s  = bcd_val(set_ss);
            ok = set_valid && h >= 0 && h <= 23 && mi >= 0 && mi <= 59 && s >= 0 && s <= 59;
            m_sec_en = 0; m_min_en = 0; m_day_en = 0; m_alarm = 0;
            m_set_err = set_valid && !ok;
            if (ok) begin
                m_secs = h * 3600 + mi * 60 + s;
                m_pre  = 0;
            end else begin
                if (run_en) m_pre = tick ? 0 : m_pre + 1;
                if (tick) begin
                    m_secs   = (m_secs + 1) % 86400;
                    m_sec_en = 1;
                    m_min_en = (m_secs % 60 == 0);
                    m_day_en = (m_secs == 0);
                    ah = bcd_val(alarm_hh);
                    am = bcd_val(alarm_mm);
                    m_alarm = alarm_en && ah >= 0 && ah <= 23 && am >= 0 && am <= 59 &&
                              (m_secs == ah * 3600 + am * 60);
                end
            end
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_set(input logic [7:0] h, input logic [7:0] mi, input logic [7:0] s);
        set_hh = h; set_mm = mi; set_ss = s; set_valid = 1'b1;
        cycle();
        set_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        checks++;
        if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL reset_vec got=%h exp=%h", dut_vec(), model_vec());
        end
        checks++;
        if (dut_vec() !== 27'd0) begin
            errors++; $display("FAIL reset_zero got=%h exp=0", dut_vec());
        end
    endtask

    task automatic test_count();
        int first_sec = -1;
        int pulses = 0;
        rst = 1'b0;
        run_en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cycle();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL count_vec k=%0d got=%h exp=%h", k, dut_vec(), model_vec());
            end
            if (sec_en === 1'b1) begin
                pulses++;
                if (first_sec < 0) first_sec = k;
            end
            if (k == 2 || k == 3) begin
                checks++;
                if (clk_slow !== (k == 3)) begin
                    errors++; $display("FAIL slow_toggle k=%0d got=%b exp=%b", k, clk_slow, (k == 3));
                end
            end
            if (k == 4) begin
                checks++;
                if (dut_time() !== hms(0, 0, 1)) begin
                    errors++; $display("FAIL first_second got=%h exp=%h", dut_time(), hms(0, 0, 1));
                end
            end
        end
        checks++;
        if (first_sec != 4 || pulses != 3) begin
            errors++; $display("FAIL sec_en_timing first=%0d pulses=%0d exp first=4 pulses=3", first_sec, pulses);
        end
    endtask

    task automatic test_rollover();
        int day_k = -1;
        run_en = 1'b1;
        do_set(8'h23, 8'h59, 8'h58);
        checks++;
        if (pm !== 1'b1 || dut_time() !== hms(23, 59, 58)) begin
            errors++; $display("FAIL rollover_load pm=%b time=%h exp pm=1 time=%h", pm, dut_time(), hms(23, 59, 58));
        end
        for (int k = 1; k <= 9; k++) begin
            cycle();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL rollover_vec k=%0d got=%h exp=%h", k, dut_vec(), model_vec());
            end
            if (day_en === 1'b1) begin
                day_k = k;
                checks++;
                if ({sec_en, min_en, pm} !== 3'b110 || dut_time() !== hms(0, 0, 0)) begin
                    errors++; $display("FAIL day_wrap sec/min/pm=%b time=%h exp 110 time=0", {sec_en, min_en, pm}, dut_time());
                end
            end
        end
        checks++;
        if (day_k != 8) begin
            errors++; $display("FAIL day_en_cycle got=%0d exp=8", day_k);
        end
    endtask

    task automatic test_display();
        run_en = 1'b0;
        mode_12h = 1'b1;
        for (int h = 0; h < 24; h++) begin
            do_set(to_bcd(h), 8'h05, 8'h00);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL disp12_vec h=%0d got=%h exp=%h", h, dut_vec(), model_vec());
            end
        end
        do_set(8'h13, 8'h05, 8'h00);
        checks++;
        if (dut_time() !== hms(1, 5, 0) || pm !== 1'b1) begin
            errors++; $display("FAIL disp_13h got=%h pm=%b exp=%h pm=1", dut_time(), pm, hms(1, 5, 0));
        end
        do_set(8'h00, 8'h30, 8'h00);
        checks++;
        if (dut_time() !== hms(12, 30, 0) || pm !== 1'b0) begin
            errors++; $display("FAIL disp_00h got=%h pm=%b exp=%h pm=0", dut_time(), pm, hms(12, 30, 0));
        end
        mode_12h = 1'b0;
        cycle();
        checks++;
        if (dut_time() !== hms(0, 30, 0)) begin
            errors++; $display("FAIL disp_24h got=%h exp=%h", dut_time(), hms(0, 30, 0));
        end
        mode_12h = 1'b1;
        cycle();
        checks++;
        if (dut_time() !== hms(12, 30, 0)) begin
            errors++; $display("FAIL disp_toggle_back got=%h exp=%h", dut_time(), hms(12, 30, 0));
        end
        mode_12h = 1'b0;
    endtask

    task automatic test_set();
        logic [7:0] bad_h [3] = '{8'h24, 8'h12, 8'h12};
        logic [7:0] bad_m [3] = '{8'h10, 8'h60, 8'h10};
        logic [7:0] bad_s [3] = '{8'h10, 8'h10, 8'h0A};
        run_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do_set(bad_h[i], bad_m[i], bad_s[i]);
            checks++;
            if (set_err !== 1'b1 || dut_time() !== hms(0, 30, 0)) begin
                errors++; $display("FAIL set_reject i=%0d err=%b time=%h exp err=1 time=%h", i, set_err, dut_time(), hms(0, 30, 0));
            end
        end
        cycle();
        checks++;
        if (set_err !== 1'b0) begin
            errors++; $display("FAIL set_err_pulse got=%b exp=0", set_err);
        end
        // Valid set landing on a tick edge: tick dropped, prescaler restarts.
        run_en = 1'b1;
        for (int i = 0; i < 8 && m_pre != T - 1; i++) cycle();
        do_set(8'h11, 8'h22, 8'h33);
        checks++;
        if (sec_en !== 1'b0 || dut_time() !== hms(11, 22, 33)) begin
            errors++; $display("FAIL set_on_tick sec_en=%b time=%h exp 0 %h", sec_en, dut_time(), hms(11, 22, 33));
        end
        for (int k = 1; k <= 4; k++) begin
            cycle();
            checks++;
            if (sec_en !== (k == 4) || dut_time() !== hms(11, 22, (k == 4) ? 34 : 33)) begin
                errors++; $display("FAIL set_restart k=%0d sec_en=%b time=%h", k, sec_en, dut_time());
            end
        end
        // Invalid set landing on a tick edge: tick proceeds.
        for (int i = 0; i < 8 && m_pre != T - 1; i++) cycle();
        do_set(8'h99, 8'h00, 8'h00);
        checks++;
        if ({set_err, sec_en} !== 2'b11 || dut_time() !== hms(11, 22, 35)) begin
            errors++; $display("FAIL bad_set_on_tick err/sec=%b time=%h exp 11 %h", {set_err, sec_en}, dut_time(), hms(11, 22, 35));
        end
    endtask

    task automatic test_alarm();
        int hits;
        run_en = 1'b1;
        alarm_hh = 8'h07; alarm_mm = 8'h00; alarm_en = 1'b1;
        do_set(8'h06, 8'h59, 8'h59);
        hits = 0;
        for (int k = 1; k <= 6; k++) begin
            cycle();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL alarm_vec k=%0d got=%h exp=%h", k, dut_vec(), model_vec());
            end
            if (alarm_hit === 1'b1) hits++;
        end
        checks++;
        if (hits != 1) begin
            errors++; $display("FAIL alarm_once got=%0d exp=1", hits);
        end
        do_set(8'h07, 8'h00, 8'h00);
        hits = (alarm_hit === 1'b1) ? 1 : 0;
        for (int k = 1; k <= 3; k++) begin
            cycle();
            if (alarm_hit === 1'b1) hits++;
        end
        checks++;
        if (hits != 0) begin
            errors++; $display("FAIL alarm_on_load got=%0d exp=0", hits);
        end
        alarm_en = 1'b0;
        do_set(8'h06, 8'h59, 8'h59);
        hits = 0;
        for (int k = 1; k <= 6; k++) begin
            cycle();
            if (alarm_hit === 1'b1) hits++;
        end
        checks++;
        if (hits != 0) begin
            errors++; $display("FAIL alarm_disabled got=%0d exp=0", hits);
        end
        alarm_en = 1'b1;
    endtask

    task automatic test_freeze();
        int toggles = 0;
        logic prev;
        run_en = 1'b1;
        do_set(8'h12, 8'h34, 8'h56);
        cycle();
        cycle();
        run_en = 1'b0;
        prev = clk_slow;
        for (int k = 1; k <= 10; k++) begin
            cycle();
            checks++;
            if (sec_en !== 1'b0 || dut_time() !== hms(12, 34, 56) || dut_vec() !== model_vec()) begin
                errors++; $display("FAIL freeze k=%0d got=%h exp=%h", k, dut_vec(), model_vec());
            end
            if (clk_slow !== prev) toggles++;
            prev = clk_slow;
        end
        checks++;
        if (toggles < 3) begin
            errors++; $display("FAIL freeze_slow toggles=%0d exp>=3", toggles);
        end
        run_en = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            cycle();
            checks++;
            if (sec_en !== (k == 2) || dut_time() !== hms(12, 34, (k == 2) ? 57 : 56)) begin
                errors++; $display("FAIL resume k=%0d sec_en=%b time=%h", k, sec_en, dut_time());
            end
        end
    endtask

    task automatic test_reset_mid();
        run_en = 1'b1;
        mode_12h = 1'b0;
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        checks++;
        if (dut_vec() !== 27'd0 || dut_vec() !== model_vec()) begin
            errors++; $display("FAIL reset_mid got=%h exp=0", dut_vec());
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        int h, mi, s, tot;
        alarm_en = 1'b1;
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            run_en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) mode_12h = ~mode_12h;
            if ($urandom_range(0, 49) == 0) alarm_en = ~alarm_en;
            set_valid = ($urandom_range(0, 24) == 0);
            if (set_valid) begin
                if ($urandom_range(0, 3) == 0) begin
                    set_hh = 8'($urandom); set_mm = 8'($urandom); set_ss = 8'($urandom);
                end else begin
                    h = $urandom_range(0, 23);
                    mi = $urandom_range(0, 59);
                    s = $urandom_range(50, 59);
                    set_hh = to_bcd(h); set_mm = to_bcd(mi); set_ss = to_bcd(s);
                    if ($urandom_range(0, 1) == 1) begin
                        tot = (h * 60 + mi + 1) % 1440;
                        alarm_hh = to_bcd(tot / 60);
                        alarm_mm = to_bcd(tot % 60);
                    end
                end
            end
            cycle();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL random i=%0d got=%h exp=%h", i, dut_vec(), model_vec());
            end
        end
        rst = 1'b0;
        set_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count();
        test_rollover();
        test_display();
        test_set();
        test_alarm();
        test_freeze();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
